// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus widths, bridge state encoding and the latched command record
package apb_pkg;
  localparam int PADDR_SIZE = 4;
  localparam int PDATA_SIZE = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef struct packed {
    logic                    write;
    logic [PADDR_SIZE-1:0]   addr;
    logic [PDATA_SIZE-1:0]   wdata;
    logic [PDATA_SIZE/8-1:0] strb;
  } cmd_t;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating count of PREADY-low ACCESS cycles; expired flags the cycle that hits the limit
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign expired = TIMEOUT_CYCLES != 0 && en && int'(cnt) + 1 >= TIMEOUT_CYCLES;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB SETUP/ACCESS transfers with a wait-state watchdog
// The command record uses the apb_pkg widths, so PADDR_SIZE/PDATA_SIZE overrides must follow the package.
module apb_master_bridge import apb_pkg::*; #(
  parameter int PADDR_SIZE     = apb_pkg::PADDR_SIZE,
  parameter int PDATA_SIZE     = apb_pkg::PDATA_SIZE,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  state_t state, nxt;
  cmd_t   cur;
  logic   expired;
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(PCLK),
    .rst(PRESET),
    .clr(state != ACCESS),
    .en(state == ACCESS && !PREADY),
    .expired(expired)
  );
  always_ff @(posedge PCLK) state <= PRESET ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE   ? (cmd_valid ? SETUP : IDLE) :
          state == SETUP  ? ACCESS :
          state == ACCESS ? (PREADY || expired ? RESP : ACCESS) :
                            (rsp_ready ? IDLE : RESP);
  end
  // APB address/data come straight from the command register, so they hold through ACCESS
  assign PWRITE = cur.write;
  assign PADDR  = cur.addr;
  assign PWDATA = cur.wdata;
  assign PSTRB  = cur.strb;
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cur         <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
    end else begin
      cmd_ready <= nxt == IDLE;
      PSEL      <= nxt == SETUP || nxt == ACCESS;
      PENABLE   <= nxt == ACCESS;
      rsp_valid <= nxt == RESP;
      if (state == IDLE && cmd_valid)
        cur <= '{write: cmd_write, addr: cmd_addr,
                 wdata: cmd_write ? cmd_wdata : '0, strb: cmd_write ? cmd_strb : '0};
      if (state == ACCESS && (PREADY || expired)) begin
        rsp_rdata   <= PREADY && !cur.write ? PRDATA : '0;
        rsp_err     <= PREADY ? PSLVERR : 1'b1;
        rsp_timeout <= !PREADY;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scenario tasks plus randomized transfers checked against a transfer-level model
module tb_apb_master_bridge;
  logic       PCLK = 0, PRESET = 1;
  logic       cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [3:0] cmd_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic       cmd_strb = 0;
  logic       rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE, PSTRB;
  logic [3:0] PADDR;
  logic [7:0] PWDATA, PRDATA = 0;
  logic       PREADY = 0, PSLVERR = 0;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0, errors = 0;
  // observations of the last transfer, filled by run_xfer
  logic       s_psel, s_pen, s_write, s_strb, r_err, r_to, i_rdy;
  logic [3:0] s_addr, pend_addr = 0;
  logic [7:0] s_wdata, r_rdata;
  int         a_cnt, r_cyc;
  bit         a_bad, r_bad, pend = 0;

  // cycle indices count from the accept edge: 1 = SETUP, 2 = first ACCESS
  task automatic run_xfer(input logic w, input logic [3:0] a, input logic [7:0] d, input logic s,
                          input int waits, input logic [7:0] rd, input logic se, input int hold);
    int g, cyc;
    bit rdy;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; PREADY = 0;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge PCLK); g++; end
    @(negedge PCLK);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
    cmd_wdata = 8'($urandom); cmd_strb = 1'($urandom);
    s_psel = PSEL; s_pen = PENABLE; s_write = PWRITE; s_addr = PADDR; s_wdata = PWDATA; s_strb = PSTRB;
    PREADY = 1; PRDATA = 8'($urandom); PSLVERR = 1'($urandom);
    a_cnt = 0; a_bad = 0;
    @(negedge PCLK);
    cyc = 2;
    while (PSEL && PENABLE && a_cnt < 40) begin
      a_cnt++;
      if (PADDR !== a || PWRITE !== w || PWDATA !== (w ? d : 8'h00) || PSTRB !== (w ? s : 1'b0)) a_bad = 1;
      rdy = a_cnt > waits;
      PREADY = rdy; PRDATA = rdy ? rd : 8'($urandom); PSLVERR = rdy ? se : 1'($urandom);
      @(negedge PCLK);
      cyc++;
    end
    PREADY = 0; PSLVERR = 0;
    r_cyc = rsp_valid ? cyc : -1;
    r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout; r_bad = 0;
    if (pend) begin cmd_valid = 1; cmd_write = 0; cmd_addr = pend_addr; end
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1 || rsp_rdata !== r_rdata || rsp_err !== r_err || rsp_timeout !== r_to || cmd_ready !== 0) r_bad = 1;
    end
    rsp_ready = 1;
    @(negedge PCLK);
    i_rdy = cmd_ready;
    if (rsp_valid !== 0) r_bad = 1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    PRESET = 1;
    repeat (3) @(negedge PCLK);
    checks++; if (cmd_ready !== 1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({PSEL, PENABLE, PWRITE, PSTRB, rsp_valid, rsp_err, rsp_timeout} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl got %b exp 0000000", {PSEL, PENABLE, PWRITE, PSTRB, rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if ({PADDR, PWDATA, rsp_rdata} !== 20'h0) begin errors++; $display("FAIL reset_data got %h exp 00000", {PADDR, PWDATA, rsp_rdata}); end
    PRESET = 0;
  endtask

  task automatic test_write_no_wait();
    run_xfer(1, 4'h3, 8'hA5, 1'b1, 0, 8'h00, 0, 0);
    checks++; if ({s_psel, s_pen, s_write} !== 3'b101) begin errors++; $display("FAIL wr_setup_ctrl got %b exp 101", {s_psel, s_pen, s_write}); end
    checks++; if (s_addr !== 4'h3 || s_wdata !== 8'hA5 || s_strb !== 1)
      begin errors++; $display("FAIL wr_setup_data got %h/%h/%b exp 3/a5/1", s_addr, s_wdata, s_strb); end
    checks++; if (a_cnt !== 1 || a_bad) begin errors++; $display("FAIL wr_access got %0d bad=%0b exp 1 bad=0", a_cnt, a_bad); end
    checks++; if (r_cyc !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", r_cyc); end
    checks++; if (r_err !== 0 || r_to !== 0 || r_rdata !== 0) begin errors++; $display("FAIL wr_rsp got %b/%b/%h exp 0/0/00", r_err, r_to, r_rdata); end
    checks++; if (i_rdy !== 1) begin errors++; $display("FAIL wr_idle got %b exp 1", i_rdy); end
  endtask

  task automatic test_read_waits();
    run_xfer(0, 4'h7, 8'hEE, 1'b1, 2, 8'h5C, 0, 0);
    checks++; if (s_write !== 0 || s_strb !== 0 || s_wdata !== 0 || s_addr !== 4'h7)
      begin errors++; $display("FAIL rd_setup got w=%b strb=%b wd=%h a=%h exp 0/0/00/7", s_write, s_strb, s_wdata, s_addr); end
    checks++; if (a_cnt !== 3 || a_bad) begin errors++; $display("FAIL rd_access got %0d bad=%0b exp 3 bad=0", a_cnt, a_bad); end
    checks++; if (r_cyc !== 5) begin errors++; $display("FAIL rd_latency got %0d exp 5", r_cyc); end
    checks++; if (r_rdata !== 8'h5C || r_err !== 0) begin errors++; $display("FAIL rd_data got %h/%b exp 5c/0", r_rdata, r_err); end
  endtask

  task automatic test_slave_err();
    run_xfer(1, 4'hF, 8'h12, 1'b1, 0, 8'h99, 1, 0);
    checks++; if (r_err !== 1 || r_to !== 0 || r_rdata !== 0)
      begin errors++; $display("FAIL slverr got %b/%b/%h exp 1/0/00", r_err, r_to, r_rdata); end
  endtask

  task automatic test_timeout();
    run_xfer(0, 4'h2, 8'h00, 1'b0, 100, 8'hAA, 0, 0);
    checks++; if (a_cnt !== 16) begin errors++; $display("FAIL to_access got %0d exp 16", a_cnt); end
    checks++; if (r_cyc !== 18) begin errors++; $display("FAIL to_latency got %0d exp 18", r_cyc); end
    checks++; if (r_err !== 1 || r_to !== 1 || r_rdata !== 0)
      begin errors++; $display("FAIL to_rsp got %b/%b/%h exp 1/1/00", r_err, r_to, r_rdata); end
    run_xfer(0, 4'h9, 8'h00, 1'b0, 1, 8'h3C, 0, 0);
    checks++; if (a_cnt !== 2 || r_rdata !== 8'h3C || r_to !== 0 || r_err !== 0)
      begin errors++; $display("FAIL to_next got %0d/%h/%b/%b exp 2/3c/0/0", a_cnt, r_rdata, r_to, r_err); end
  endtask

  task automatic test_back_to_back();
    int g;
    pend = 1; pend_addr = 4'hB;
    run_xfer(1, 4'h4, 8'h11, 1'b1, 0, 8'h00, 0, 3);
    pend = 0;
    checks++; if (r_bad) begin errors++; $display("FAIL b2b_hold got unstable exp stable"); end
    checks++; if (i_rdy !== 1) begin errors++; $display("FAIL b2b_idle got %b exp 1", i_rdy); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 4'hB)
      begin errors++; $display("FAIL b2b_accept got %b/%h exp 100/b", {PSEL, PENABLE, PWRITE}, PADDR); end
    cmd_valid = 0; PREADY = 1; PRDATA = 8'h77; PSLVERR = 0;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge PCLK); g++; end
    checks++; if (rsp_valid !== 1 || rsp_rdata !== 8'h77) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/77", rsp_valid, rsp_rdata); end
    PREADY = 0; rsp_ready = 1;
    @(negedge PCLK);
    rsp_ready = 0;
  endtask

  task automatic test_mid_reset();
    int g;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h5; cmd_wdata = 8'h42; cmd_strb = 1; PREADY = 0;
    g = 0;
    while (!(PSEL && PENABLE) && g < 20) begin
      if (PSEL) cmd_valid = 0;
      @(negedge PCLK);
      g++;
    end
    cmd_valid = 0;
    checks++; if (!(PSEL && PENABLE)) begin errors++; $display("FAIL mrst_access got %b%b exp 11", PSEL, PENABLE); end
    @(negedge PCLK);
    PRESET = 1;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin errors++; $display("FAIL mrst_drop got %b exp 000", {PSEL, PENABLE, rsp_valid}); end
    checks++; if (cmd_ready !== 1) begin errors++; $display("FAIL mrst_ready got %b exp 1", cmd_ready); end
    PRESET = 0;
    run_xfer(0, 4'h1, 8'h00, 1'b0, 0, 8'hC3, 0, 0);
    checks++; if (r_cyc !== 3 || r_rdata !== 8'hC3) begin errors++; $display("FAIL mrst_after got %0d/%h exp 3/c3", r_cyc, r_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic w, s, se;
      logic [3:0] a;
      logic [7:0] d, rd, exp_rd;
      int waits, hold, exp_a;
      bit exp_to;
      w = 1'($urandom); s = 1'($urandom); se = 1'($urandom);
      a = 4'($urandom); d = 8'($urandom); rd = 8'($urandom);
      waits = ($urandom % 6 == 0) ? 16 + int'($urandom % 4) : int'($urandom % 4);
      hold = int'($urandom % 3);
      exp_to = waits >= 16;
      exp_a = exp_to ? 16 : waits + 1;
      exp_rd = (w || exp_to) ? 8'h00 : rd;
      run_xfer(w, a, d, s, waits, rd, se, hold);
      checks++; if (s_psel !== 1 || s_pen !== 0 || s_addr !== a || s_write !== w || s_wdata !== (w ? d : 8'h00) || s_strb !== (w ? s : 1'b0))
        begin errors++; $display("FAIL rnd%0d_setup got %b%b/%h/%b/%h/%b exp 10/%h/%b/%h/%b", n, s_psel, s_pen, s_addr, s_write, s_wdata, s_strb, a, w, w ? d : 8'h00, w ? s : 1'b0); end
      checks++; if (a_cnt !== exp_a || a_bad) begin errors++; $display("FAIL rnd%0d_access got %0d bad=%0b exp %0d bad=0", n, a_cnt, a_bad, exp_a); end
      checks++; if (r_cyc !== 2 + exp_a) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, r_cyc, 2 + exp_a); end
      checks++; if (r_rdata !== exp_rd || r_err !== (exp_to | se) || r_to !== exp_to)
        begin errors++; $display("FAIL rnd%0d_rsp got %h/%b/%b exp %h/%b/%b", n, r_rdata, r_err, r_to, exp_rd, exp_to | se, exp_to); end
      checks++; if (r_bad || i_rdy !== 1) begin errors++; $display("FAIL rnd%0d_handshake got bad=%0b rdy=%b exp 0/1", n, r_bad, i_rdy); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_write_no_wait();
    test_read_waits();
    test_slave_err();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Initiator end of the team's APB bus; drives the PSEL/PENABLE/PADDR/PSTRB/PWDATA/PWRITE group that the device under test samples. Converts a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response stream. Adds a wait-state watchdog so a responder that never asserts PREADY cannot hang the bench or the SoC path.

Parameters:
PADDR_SIZE, 4, APB address width.
PDATA_SIZE, 8, APB data width; must be a multiple of 8. PSTRB is PDATA_SIZE/8 bits.
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the watchdog.

Ports:
PCLK  in  1  single clock; all logic on rising edge.
PRESET  in  1  synchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  bridge accepts a command this cycle.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  PADDR_SIZE  target address.
cmd_wdata  in  PDATA_SIZE  write data; ignored for reads.
cmd_strb  in  PDATA_SIZE/8  write byte strobes; ignored for reads.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes response.
rsp_rdata  out  PDATA_SIZE  read data; 0 for writes and timeouts.
rsp_err  out  1  PSLVERR seen, or timeout.
rsp_timeout  out  1  transfer aborted by the watchdog.
PSEL, PENABLE, PWRITE  out  1 each  APB control.
PADDR  out  PADDR_SIZE; PSTRB  out  PDATA_SIZE/8; PWDATA  out  PDATA_SIZE.
PRDATA  in  PDATA_SIZE; PREADY  in  1; PSLVERR  in  1.

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESET is synchronous and active-high.
- All outputs are registered. On PRESET the FSM goes to IDLE, and every output is 0 except cmd_ready, which is 1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid&cmd_ready, latch write/addr/wdata/strb and go to SETUP.
  - cmd_ready is 0 in every other state.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0.
  - PADDR and PWRITE come from the latched command.
  - Writes: PWDATA=latched wdata, PSTRB=latched strb.
  - Reads: PWDATA=0, PSTRB=0.
  - Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB hold their SETUP values.
  - PREADY=1: sample PSLVERR. For reads, sample PRDATA into rsp_rdata; for writes, rsp_rdata=0. rsp_err=PSLVERR, rsp_timeout=0. Go to RESP.
  - PREADY=0: increment the wait counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PSLVERR and PRDATA are ignored whenever PREADY=0.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. Response fields are stable until rsp_valid&rsp_ready, then go to IDLE.
- The wait counter is cleared on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1), with a minimum of 1, and it saturates.
- Latency with PREADY already high in ACCESS and rsp_ready tied high:
  - Command accepted at cycle N.
  - SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, IDLE at N+4.
  - Throughput is one transfer per 4 cycles. Each PREADY-low cycle adds 1.
- Boundaries:
  - PREADY asserted during SETUP is ignored.
  - PRESET asserted mid-transfer drops PSEL/PENABLE the following cycle and discards the pending response.
  - cmd_valid during a non-IDLE state is held off (not lost), because cmd_ready=0.
  - A timeout abort returns PSEL=0 the cycle after the limit is reached; no ACCESS completes afterwards.

Decomposition:
- Package apb_pkg holds the PADDR_SIZE/PDATA_SIZE defaults, the state enum {IDLE, SETUP, ACCESS, RESP}, and a packed command struct (write, addr, wdata, strb).
- One sub-module, apb_wait_timer: clear and enable inputs, an expired output, parameterised by TIMEOUT_CYCLES.
- The FSM and datapath registers stay in apb_master_bridge.

Test Plan:
1. Write, no waits: cmd addr=4'h3, wdata=8'hA5, strb=1. Expect:
   - SETUP with PSEL=1, PENABLE=0, PADDR=3, PWDATA=A5, PWRITE=1.
   - ACCESS the next cycle.
   - rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
2. Read with 2 wait states: addr=4'h7; responder holds PREADY=0 for 2 ACCESS cycles, then PRDATA=8'h5C with PREADY=1. Expect:
   - PADDR, PWRITE=0 and PSTRB=0 stable for all 3 ACCESS cycles.
   - rsp_rdata=5C at N+5.
3. Slave error: write addr=4'hF; responder returns PREADY=1, PSLVERR=1. Expect rsp_err=1, rsp_timeout=0.
4. Timeout: TIMEOUT_CYCLES=16, PREADY held 0. Expect:
   - Exactly 16 ACCESS cycles, then PSEL=0.
   - rsp_valid=1 with rsp_err=1, rsp_timeout=1.
   - The next command proceeds normally.
5. Backpressure and back-to-back: rsp_ready=0 for 3 cycles, with cmd_valid held. Expect:
   - Response stable while rsp_ready=0.
   - cmd_ready=0 throughout.
   - The second command is accepted exactly one cycle after the response handshake.
6. Mid-transfer reset: PRESET=1 during ACCESS. Expect:
   - PSEL=0, PENABLE=0 and rsp_valid=0 on the next edge.
   - cmd_ready=1 after reset.
